instr_fetch: RTL and testbench

- Front end of the rv32i-pico core; the producer side of the decode interface.
- Generates the PC and requests words from instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents instructions to decode over a valid/ready channel, with pre-sliced opcode/func3 for the controller.
- Handles redirects (jumps/branches) by flushing buffered and in-flight words.

---
 rtl/rv32i_pkg.sv | 20 ++
 rtl/instr_fetch_if.sv | 33 +++
 rtl/sync_fifo.sv | 60 ++++++
 rtl/instr_fetch.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i-pico types, widths and field positions
package rv32i_pkg;

    localparam int XLEN       = 32;
    localparam int ILEN       = 32;
    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_W   = 7;
    localparam int FUNC3_LSB  = 12;
    localparam int FUNC3_W    = 3;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch unit bus: imem request/response, decode channel, redirect
interface instr_fetch_if;
    import rv32i_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [XLEN-1:0]     imem_req_addr;
    logic                imem_rsp_valid;
    logic [ILEN-1:0]     imem_rsp_data;
    logic                instr_valid;
    logic                instr_ready;
    logic [ILEN-1:0]     instr_data;
    logic [XLEN-1:0]     instr_pc;
    logic [OPCODE_W-1:0] opcode;
    logic [FUNC3_W-1:0]  func3;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_valid, instr_data, instr_pc, opcode, func3,
        input  instr_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_valid, instr_data, instr_pc, opcode, func3,
        output instr_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and occupancy count
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    // A full FIFO may still take a push when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - rv32i-pico fetch front end: PC generation, imem requests, instruction FIFO
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input logic         clk,
    input logic         rst,
    instr_fetch_if.master bus
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic            started_q;

    logic            redirect;
    logic [CW:0]     occupancy;
    logic            credit_ok;
    logic            req_valid;
    logic            req_fire;
    logic            rsp_ok;
    logic            rsp_keep;
    logic            head_valid;

    logic                q_push, q_pop, q_full, q_empty;
    logic [2*XLEN-1:0]   q_din, q_dout;
    logic [CW-1:0]       q_count;

    logic                pcq_push, pcq_pop, pcq_full, pcq_empty;
    logic [XLEN-1:0]     pcq_dout;
    logic [CW-1:0]       pcq_count;

    assign redirect  = bus.redirect_valid;
    assign occupancy = {1'b0, inflight_q} + {1'b0, q_count};
    assign credit_ok = occupancy < (CW+1)'(DEPTH);

    // started_q keeps requests off for one full cycle after reset releases.
    assign req_valid = started_q && !rst && (state_q == FETCH) && !redirect && credit_ok;
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign rsp_ok    = bus.imem_rsp_valid && (inflight_q != '0);
    assign rsp_keep  = rsp_ok && !redirect && (state_q == FETCH) && (discard_q == '0);

    assign head_valid = !q_empty && !rst;

    assign q_push  = rsp_keep;
    assign q_din   = {pcq_dout, bus.imem_rsp_data};
    assign q_pop   = head_valid && bus.instr_ready && !redirect;

    assign pcq_push = req_fire;
    assign pcq_pop  = rsp_keep;

    // PCs of issued requests, consumed in order as their responses return.
    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (pcq_push),
        .push_data (pc_q),
        .pop       (pcq_pop),
        .pop_data  (pcq_dout),
        .full      (pcq_full),
        .empty     (pcq_empty),
        .count     (pcq_count)
    );

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (q_push),
        .push_data (q_din),
        .pop       (q_pop),
        .pop_data  (q_dout),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_ok);
        if (redirect) begin
            pc_d      = align_word(bus.redirect_pc);
            discard_d = inflight_d;
            state_d   = (inflight_d != '0) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_fire) begin
                        pc_d = pc_q + XLEN'(4);
                    end
                end
                DRAIN: begin
                    if (discard_q == '0) begin
                        state_d = FETCH;
                    end else if (rsp_ok) begin
                        discard_d = discard_q - CW'(1);
                        if (discard_q == CW'(1)) begin
                            state_d = FETCH;
                        end
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            started_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(bus.imem_rsp_valid && inflight_q == '0))
                else $error("instr_fetch: response with nothing in flight");
            assert (!(q_push && q_full && !q_pop))
                else $error("instr_fetch: instruction FIFO overflow");
            assert (!(pcq_push && pcq_full))
                else $error("instr_fetch: pc FIFO overflow");
            assert (!(pcq_pop && pcq_empty))
                else $error("instr_fetch: pc FIFO underflow");
            assert (state_q != FETCH || pcq_count == inflight_q)
                else $error("instr_fetch: pc FIFO out of step with in-flight count");
            assert (discard_q <= inflight_q)
                else $error("instr_fetch: discard exceeds in-flight count");
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.instr_valid    = head_valid;
    assign bus.instr_data     = q_dout[ILEN-1:0];
    assign bus.instr_pc       = q_dout[2*XLEN-1:XLEN];
    assign bus.opcode         = q_dout[OPCODE_LSB +: OPCODE_W];
    assign bus.func3          = q_dout[FUNC3_LSB +: FUNC3_W];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    instr_fetch_if bus();

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] target;
        int          lat;
        bit          toggle;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    int  cyc       = 0;
    int  mem_lat   = 1;
    bit  rdy_tog   = 1'b0;
    mreq_t memq[$];

    logic [31:0] req_log[$];
    logic [31:0] dlv_pc[$];
    logic [31:0] dlv_data[$];
    logic [6:0]  dlv_op[$];
    logic [2:0]  dlv_f3[$];
    int          rsp_seen;
    int          rsp_before_req;
    bit          stall_prev;
    logic [31:0] stall_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h5A5A_3013);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        dlv_pc.delete();
        dlv_data.delete();
        dlv_op.delete();
        dlv_f3.delete();
        rsp_seen       = 0;
        rsp_before_req = -1;
    endtask

    task automatic wait_sizes(input int nreq, input int ndlv, input string name);
        int n;
        n = 0;
        while ((req_log.size() < nreq || dlv_pc.size() < ndlv) && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (req_log.size() < nreq || dlv_pc.size() < ndlv) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual_req=%0d actual_dlv=%0d required_req=%0d required_dlv=%0d",
                     name, req_log.size(), dlv_pc.size(), nreq, ndlv);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
    endtask

    // Memory model: in order, fixed latency, optional toggling request ready.
    always begin
        @(negedge clk);
        if (rst) begin
            memq.delete();
        end else if (bus.imem_req_valid && bus.imem_req_ready) begin
            memq.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
        end
        @(posedge clk);
        cyc++;
        #1;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = 32'h0;
        end
        bus.imem_req_ready = rdy_tog ? ~bus.imem_req_ready : 1'b1;
    end

    // Mid-cycle monitor: request/delivery logs and stalled-request stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev && !bus.redirect_valid) begin
                checks++;
                if (!(bus.imem_req_valid === 1'b1 && bus.imem_req_addr === stall_addr)) begin
                    failures++;
                    $display("FAIL stall_hold actual_valid=%b actual_addr=%h expected_addr=%h",
                             bus.imem_req_valid, bus.imem_req_addr, stall_addr);
                end
            end
            stall_prev = bus.imem_req_valid && !bus.imem_req_ready;
            stall_addr = bus.imem_req_addr;
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                if (req_log.size() == 0) rsp_before_req = rsp_seen;
                req_log.push_back(bus.imem_req_addr);
            end
            if (bus.imem_rsp_valid) rsp_seen++;
            if (bus.instr_valid && bus.instr_ready) begin
                dlv_pc.push_back(bus.instr_pc);
                dlv_data.push_back(bus.instr_data);
                dlv_op.push_back(bus.opcode);
                dlv_f3.push_back(bus.func3);
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    vec_t tbl[4];

    initial begin
        int n;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        clear_logs();

        tbl[0] = '{32'h0000_0040, 1, 1'b0, 32'h0000_0040, 32'h0000_0044, 32'h0000_0048};
        tbl[1] = '{32'h0000_0103, 3, 1'b0, 32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
        tbl[2] = '{32'hFFFF_FFF8, 1, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        tbl[3] = '{32'h0000_1002, 2, 1'b1, 32'h0000_1000, 32'h0000_1004, 32'h0000_1008};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid",   {31'b0, bus.imem_req_valid}, 32'h0);
        chk("rst_instr_valid", {31'b0, bus.instr_valid},    32'h0);
        chk("rst_req_addr",    bus.imem_req_addr,           32'h0);
        chk("rst_instr_data",  bus.instr_data,              32'h0);
        chk("rst_instr_pc",    bus.instr_pc,                32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_logs();
        @(negedge clk);
        chk("post_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'h0);
        @(negedge clk);
        chk("boot_req_valid", {31'b0, bus.imem_req_valid}, 32'h1);
        chk("boot_req_addr",  bus.imem_req_addr,           32'h0);

        // Boot stream with 1-cycle memory
        wait_sizes(3, 3, "boot");
        chk("boot_req0", req_log[0], 32'h0);
        chk("boot_req1", req_log[1], 32'h4);
        chk("boot_req2", req_log[2], 32'h8);
        chk("boot_pc0",  dlv_pc[0],  32'h0);
        chk("boot_pc1",  dlv_pc[1],  32'h4);
        chk("boot_pc2",  dlv_pc[2],  32'h8);
        chk("boot_data0", dlv_data[0], 32'h0050_0093);
        chk("boot_opcode", {25'b0, dlv_op[0]}, 32'h13);
        chk("boot_func3",  {29'b0, dlv_f3[0]}, 32'h0);

        // Decode stalled: credit stops requests at DEPTH
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (12) @(negedge clk);
        #1;
        chk("stall_req_count",   req_log.size(),               32'd2);
        chk("stall_req_valid",   {31'b0, bus.imem_req_valid},  32'h0);
        chk("stall_instr_valid", {31'b0, bus.instr_valid},     32'h1);
        chk("stall_head_pc",     bus.instr_pc,                 32'h0);
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        wait_sizes(3, 3, "resume");
        chk("resume_req2", req_log[2], 32'h8);
        chk("resume_pc0",  dlv_pc[0],  32'h0);
        chk("resume_pc1",  dlv_pc[1],  32'h4);
        chk("resume_pc2",  dlv_pc[2],  32'h8);

        // 3-cycle memory, redirect with two words in flight
        mem_lat = 3;
        do_reset();
        wait_sizes(2, 0, "drain_setup");
        chk("drain_inflight", memq.size(), 32'd2);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        clear_logs();
        wait_sizes(1, 1, "drain");
        chk("drain_dropped",  rsp_before_req, 32'd2);
        chk("drain_req0",     req_log[0],     32'h0000_0100);
        chk("drain_pc0",      dlv_pc[0],      32'h0000_0100);
        chk("drain_data0",    dlv_data[0],    mem_word(32'h0000_0100));

        // Redirect coinciding with a response and a pop
        mem_lat = 1;
        do_reset();
        n = 0;
        while (!(bus.imem_rsp_valid && bus.instr_valid && bus.instr_ready) && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("coinc_found", {31'b0, bus.imem_rsp_valid && bus.instr_valid}, 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        clear_logs();
        @(negedge clk);
        #1;
        chk("coinc_instr_valid", {31'b0, bus.instr_valid},    32'h0);
        chk("coinc_req_valid",   {31'b0, bus.imem_req_valid}, 32'h1);
        chk("coinc_req_addr",    bus.imem_req_addr,           32'h0000_0200);
        wait_sizes(1, 1, "coinc");
        chk("coinc_pc0", dlv_pc[0], 32'h0000_0200);

        // Table of redirect targets over a running stream
        for (int i = 0; i < 4; i++) begin
            mem_lat = tbl[i].lat;
            rdy_tog = tbl[i].toggle;
            @(posedge clk);
            #1;
            bus.redirect_valid = 1'b1;
            bus.redirect_pc    = tbl[i].target;
            @(posedge clk);
            #1;
            bus.redirect_valid = 1'b0;
            clear_logs();
            wait_sizes(3, 3, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d_req0", i),  req_log[0],  tbl[i].e0);
            chk($sformatf("vec%0d_req1", i),  req_log[1],  tbl[i].e1);
            chk($sformatf("vec%0d_req2", i),  req_log[2],  tbl[i].e2);
            chk($sformatf("vec%0d_pc0", i),   dlv_pc[0],   tbl[i].e0);
            chk($sformatf("vec%0d_pc1", i),   dlv_pc[1],   tbl[i].e1);
            chk($sformatf("vec%0d_pc2", i),   dlv_pc[2],   tbl[i].e2);
            chk($sformatf("vec%0d_data0", i), dlv_data[0], mem_word(tbl[i].e0));
            chk($sformatf("vec%0d_data1", i), dlv_data[1], mem_word(tbl[i].e1));
            chk($sformatf("vec%0d_data2", i), dlv_data[2], mem_word(tbl[i].e2));
        end
        rdy_tog = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
